// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note-on/off events onto VOICES envelope gates,
// reusing a matching voice, taking a free one, or stealing the oldest.
module voice_allocator #(
    parameter int VOICES    = 4,
    parameter int NOTE_BITS = 7,
    parameter int AGE_BITS  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic                          ev_note_on,
    input  logic [NOTE_BITS-1:0]          ev_note,
    input  logic [VOICES-1:0]             voice_active,
    output logic [VOICES-1:0]             gate,
    output logic [VOICES*NOTE_BITS-1:0]   voice_note,
    output logic                          alloc_valid,
    output logic [$clog2(VOICES)-1:0]     alloc_voice,
    output logic                          alloc_stolen
);
    localparam int IDX_W = $clog2(VOICES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] GAP    = 2'd2;
    localparam logic [1:0] ASSIGN = 2'd3;

    logic [1:0]           state;
    logic                 note_on_p0;
    logic [NOTE_BITS-1:0] note_p0;
    logic [IDX_W-1:0]     target;
    logic                 stolen;
    logic [AGE_BITS-1:0]  age [VOICES];

    logic                 match_hit, free_hit, rel_hit, busy_hit;
    logic [IDX_W-1:0]     match_idx, free_idx, rel_idx, busy_idx;
    logic [AGE_BITS-1:0]  rel_age, busy_age;
    logic [IDX_W-1:0]     lk_target;
    logic                 lk_stolen;
    logic [1:0]           lk_next;

    function automatic logic [AGE_BITS-1:0] age_inc(input logic [AGE_BITS-1:0] a);
        return (&a) ? a : a + 1'b1;
    endfunction

    assign ev_ready = (state == IDLE);

    // Candidate search; strict '>' keeps age ties on the lowest index.
    always_comb begin
        match_hit = 1'b0; match_idx = '0;
        free_hit  = 1'b0; free_idx  = '0;
        rel_hit   = 1'b0; rel_idx   = '0; rel_age  = '0;
        busy_hit  = 1'b0; busy_idx  = '0; busy_age = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (!match_hit && gate[i] && voice_note[i*NOTE_BITS +: NOTE_BITS] == note_p0) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!free_hit && !gate[i] && !voice_active[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (!gate[i] && voice_active[i] && (!rel_hit || age[i] > rel_age)) begin
                rel_hit = 1'b1;
                rel_idx = IDX_W'(i);
                rel_age = age[i];
            end
            if (gate[i] && (!busy_hit || age[i] > busy_age)) begin
                busy_hit = 1'b1;
                busy_idx = IDX_W'(i);
                busy_age = age[i];
            end
        end
    end

    always_comb begin
        lk_target = '0;
        lk_stolen = 1'b0;
        lk_next   = IDLE;
        if (note_on_p0) begin
            if (match_hit) begin
                lk_target = match_idx;
                lk_next   = GAP;
            end else if (free_hit) begin
                lk_target = free_idx;
                lk_next   = ASSIGN;
            end else if (rel_hit) begin
                lk_target = rel_idx;
                lk_stolen = 1'b1;
                lk_next   = GAP;
            end else begin
                lk_target = busy_idx;
                lk_stolen = 1'b1;
                lk_next   = GAP;
            end
        end else if (match_hit) begin
            lk_target = match_idx;
            lk_next   = ASSIGN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            gate         <= '0;
            voice_note   <= '0;
            alloc_valid  <= 1'b0;
            alloc_voice  <= '0;
            alloc_stolen <= 1'b0;
            for (int i = 0; i < VOICES; i++) age[i] <= '0;
        end else begin
            alloc_valid <= 1'b0;
            case (state)
                IDLE:   if (ev_valid) state <= LOOKUP;
                LOOKUP: state <= lk_next;
                GAP: begin
                    gate[target] <= 1'b0;
                    state        <= ASSIGN;
                end
                ASSIGN: begin
                    state <= IDLE;
                    if (note_on_p0) begin
                        gate[target]                             <= 1'b1;
                        voice_note[target*NOTE_BITS +: NOTE_BITS] <= note_p0;
                        alloc_valid                              <= 1'b1;
                        alloc_voice                              <= target;
                        alloc_stolen                             <= stolen;
                        for (int i = 0; i < VOICES; i++)
                            age[i] <= (IDX_W'(i) == target) ? '0 : age_inc(age[i]);
                    end else begin
                        // Matched note-off: release the gate only; ages untouched.
                        gate[target] <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && ev_valid) begin
            note_on_p0 <= ev_note_on;
            note_p0    <= ev_note;
        end
        if (state == LOOKUP) begin
            target <= lk_target;
            stolen <= lk_stolen;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: event-level allocation model with per-cycle output checks.
module tb_voice_allocator;
    logic        clk;
    logic        reset;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_note_on;
    logic [6:0]  ev_note;
    logic [3:0]  voice_active;
    logic [3:0]  gate;
    logic [27:0] voice_note;
    logic        alloc_valid;
    logic [1:0]  alloc_voice;
    logic        alloc_stolen;

    voice_allocator #(.VOICES(4), .NOTE_BITS(7), .AGE_BITS(8)) dut (
        .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_note_on(ev_note_on), .ev_note(ev_note), .voice_active(voice_active),
        .gate(gate), .voice_note(voice_note), .alloc_valid(alloc_valid),
        .alloc_voice(alloc_voice), .alloc_stolen(alloc_stolen)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    bit         chk_en = 0;

    bit         mgate [4];
    logic [6:0] mnote [4];
    int         mage  [4];
    bit         exp_ready;
    bit         exp_av;
    int         exp_avoice;
    bit         exp_astolen;
    logic [3:0]  eg;
    logic [27:0] en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mgate[i] = 1'b0;
            mnote[i] = '0;
            mage[i]  = 0;
        end
        exp_ready   = 1'b1;
        exp_av      = 1'b0;
        exp_avoice  = 0;
        exp_astolen = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                eg[i]         = mgate[i];
                en[i*7 +: 7]  = mnote[i];
            end
            check("ev_ready", 32'(ev_ready), 32'(exp_ready));
            check("gate", 32'(gate), 32'(eg));
            check("voice_note", 32'(voice_note), 32'(en));
            check("alloc_valid", 32'(alloc_valid), 32'(exp_av));
            check("alloc_voice", 32'(alloc_voice), exp_avoice);
            check("alloc_stolen", 32'(alloc_stolen), 32'(exp_astolen));
        end
    end

    // Drives one event and advances the model along the expected cycle timeline.
    task automatic send(input bit on, input int note);
        int  m, f, r, b, t;
        bit  gap, stl;
        ev_valid   = 1'b1;
        ev_note_on = on;
        ev_note    = 7'(note);
        @(posedge clk); #1;
        ev_valid  = 1'b0;
        exp_ready = 1'b0;
        m = -1; f = -1; r = -1; b = -1;
        for (int i = 0; i < 4; i++) begin
            if (m < 0 && mgate[i] && int'(mnote[i]) == note) m = i;
            if (f < 0 && !mgate[i] && !voice_active[i]) f = i;
            if (!mgate[i] && voice_active[i] && (r < 0 || mage[i] > mage[r])) r = i;
            if (mgate[i] && (b < 0 || mage[i] > mage[b])) b = i;
        end
        @(posedge clk); #1;
        if (!on) begin
            if (m < 0) begin
                exp_ready = 1'b1;
                return;
            end
            @(posedge clk); #1;
            mgate[m]  = 1'b0;
            exp_ready = 1'b1;
            return;
        end
        stl = (m < 0) && (f < 0);
        gap = (m >= 0) || (f < 0);
        t   = (m >= 0) ? m : (f >= 0) ? f : (r >= 0) ? r : b;
        if (gap) begin
            @(posedge clk); #1;
            mgate[t] = 1'b0;
        end
        @(posedge clk); #1;
        mgate[t] = 1'b1;
        mnote[t] = 7'(note);
        for (int j = 0; j < 4; j++)
            mage[j] = (j == t) ? 0 : ((mage[j] < 255) ? mage[j] + 1 : 255);
        exp_av      = 1'b1;
        exp_avoice  = t;
        exp_astolen = stl;
        exp_ready   = 1'b1;
        @(posedge clk); #1;
        exp_av = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        ev_valid     = 1'b0;
        ev_note_on   = 1'b0;
        ev_note      = '0;
        voice_active = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_gate", 32'(gate), 32'd0);
        check("rst_ready", 32'(ev_ready), 32'd1);
        check("rst_voice_note", 32'(voice_note), 32'd0);
        check("rst_alloc_valid", 32'(alloc_valid), 32'd0);
        reset  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        send(1, 60);
        check("first_gate", 32'(gate), 32'b0001);
        check("first_note", 32'(voice_note[6:0]), 32'd60);
        check("first_voice", 32'(alloc_voice), 32'd0);
        check("first_stolen", 32'(alloc_stolen), 32'd0);

        voice_active = 4'b0001; send(1, 62);
        voice_active = 4'b0011; send(1, 64);
        voice_active = 4'b0111; send(1, 65);
        voice_active = 4'b1111;
        check("full_gate", 32'(gate), 32'hF);
        check("full_notes", 32'(voice_note), 32'({7'd65, 7'd64, 7'd62, 7'd60}));

        send(1, 67);
        check("steal_voice", 32'(alloc_voice), 32'd0);
        check("steal_stolen", 32'(alloc_stolen), 32'd1);
        check("steal_note", 32'(voice_note[6:0]), 32'd67);

        send(0, 62);
        check("off62_gate", 32'(gate), 32'b1101);
        send(1, 70);
        check("rel_voice", 32'(alloc_voice), 32'd1);
        check("rel_stolen", 32'(alloc_stolen), 32'd1);

        send(0, 70);
        voice_active = 4'b1101;
        send(1, 72);
        check("free_voice", 32'(alloc_voice), 32'd1);
        check("free_stolen", 32'(alloc_stolen), 32'd0);
        voice_active = 4'b1111;

        // Reset asserted while a steal sits in its gate-low gap cycle.
        chk_en     = 1'b0;
        ev_valid   = 1'b1;
        ev_note_on = 1'b1;
        ev_note    = 7'd74;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        check("async_gate", 32'(gate), 32'd0);
        check("async_ready", 32'(ev_ready), 32'd1);
        check("async_notes", 32'(voice_note), 32'd0);
        model_reset();
        voice_active = '0;
        @(posedge clk); #1;
        reset  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        send(1, 60);
        check("post_rst_voice", 32'(alloc_voice), 32'd0);
        check("post_rst_stolen", 32'(alloc_stolen), 32'd0);
        voice_active = 4'b0001;
        send(1, 60);
        check("retrig_gate", 32'(gate), 32'b0001);
        check("retrig_voice", 32'(alloc_voice), 32'd0);
        check("retrig_stolen", 32'(alloc_stolen), 32'd0);

        send(0, 50);
        check("off50_gate", 32'(gate), 32'b0001);
        send(0, 60);
        send(0, 60);
        check("off_releasing_gate", 32'(gate), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
